// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs load/store transactions against the data cache
// over a req/ready handshake and registers the MEM/WB bundle for write-back.
// Optional build macro MEM_TIMEOUT_EN adds an ACCESS-state watchdog that
// aborts a transaction after TIMEOUT_CYCLES cycles and raises mem_error.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        is_word_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_num_in,
    input  logic [1:0]  register_src_in,
    input  logic [31:0] inst_addr_in,
    input  logic        halted_in,
    output logic        stall,
    output logic        cache_req,
    output logic        cache_we,
    output logic [31:0] cache_addr,
    output logic [3:0]  cache_be,
    output logic [31:0] cache_wdata,
    input  logic        cache_ready,
    input  logic [31:0] cache_rdata,
    output logic        wb_valid,
    output logic [1:0]  wb_register_src,
    output logic [4:0]  wb_rd_num,
    output logic        wb_is_word,
    output logic [1:0]  wb_byte_number,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_inst_addr,
    output logic [31:0] wb_cache_data,
    output logic        wb_halted,
    output logic        mem_error
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q;

    // Bundle latched on accept, held stable for the whole transaction
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        load_q;
    logic        is_word_q;
    logic [4:0]  rd_num_q;
    logic [1:0]  reg_src_q;
    logic [31:0] inst_addr_q;
    logic        halted_q;

    // MEM/WB registers
    logic        wb_valid_q;
    logic [1:0]  wb_register_src_q;
    logic [4:0]  wb_rd_num_q;
    logic        wb_is_word_q;
    logic [1:0]  wb_byte_number_q;
    logic [31:0] wb_alu_result_q;
    logic [31:0] wb_inst_addr_q;
    logic [31:0] wb_cache_data_q;
    logic        wb_halted_q;

    logic        accept;
    logic        is_mem;
    logic        timeout_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    // Once a halt has retired the stage ignores all further bundles
    assign accept = in_valid && !wb_halted_q;
    assign is_mem = mem_read || mem_write;

`ifdef MEM_TIMEOUT_EN
    logic [31:0] cnt_q;
    logic        mem_error_q;

    assign timeout_hit = (state_q == ACCESS) && !cache_ready &&
                         (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign mem_error   = mem_error_q;

    // Watchdog: cleared on entry to ACCESS, counts cycles without cache_ready
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q       <= '0;
            mem_error_q <= 1'b0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (timeout_hit) begin
            cnt_q       <= '0;
            mem_error_q <= 1'b1;
        end else if (!cache_ready) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end
`else
    // No watchdog in this build: never aborts, error flag is constant zero
    assign timeout_hit = 1'b0;
    assign mem_error   = (TIMEOUT_CYCLES < 0);
`endif

    // Lane steering for the request: byte 0 lives in bits 31:24
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data;
        if (!is_word_in) begin
            be_d    = 4'b1000 >> alu_result_in[1:0];
            wdata_d = {4{store_data[7:0]}};
        end
    end

    // Upstream hold: accept cycle of a mem op, then every ACCESS cycle until done
    always_comb begin
        stall = 1'b0;
        if (rst_b) begin
            if (state_q == IDLE) begin
                stall = accept && is_mem;
            end else begin
                stall = !(cache_ready || timeout_hit);
            end
        end
    end

    assign cache_req   = (state_q == ACCESS);
    assign cache_we    = we_q;
    assign cache_addr  = {addr_q[31:2], 2'b00};
    assign cache_be    = be_q;
    assign cache_wdata = wdata_q;

    assign wb_valid        = wb_valid_q;
    assign wb_register_src = wb_register_src_q;
    assign wb_rd_num       = wb_rd_num_q;
    assign wb_is_word      = wb_is_word_q;
    assign wb_byte_number  = wb_byte_number_q;
    assign wb_alu_result   = wb_alu_result_q;
    assign wb_inst_addr    = wb_inst_addr_q;
    assign wb_cache_data   = wb_cache_data_q;
    assign wb_halted       = wb_halted_q;

    // Stage FSM: accept, run the cache handshake, retire into MEM/WB
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            wdata_q           <= '0;
            be_q              <= '0;
            we_q              <= 1'b0;
            load_q            <= 1'b0;
            is_word_q         <= 1'b0;
            rd_num_q          <= '0;
            reg_src_q         <= '0;
            inst_addr_q       <= '0;
            halted_q          <= 1'b0;
            wb_valid_q        <= 1'b0;
            wb_register_src_q <= '0;
            wb_rd_num_q       <= '0;
            wb_is_word_q      <= 1'b0;
            wb_byte_number_q  <= '0;
            wb_alu_result_q   <= '0;
            wb_inst_addr_q    <= '0;
            wb_cache_data_q   <= '0;
            wb_halted_q       <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && is_mem) begin
                        addr_q      <= alu_result_in;
                        wdata_q     <= wdata_d;
                        be_q        <= be_d;
                        we_q        <= mem_write;
                        load_q      <= mem_read && !mem_write;
                        is_word_q   <= is_word_in;
                        rd_num_q    <= rd_num_in;
                        reg_src_q   <= register_src_in;
                        inst_addr_q <= inst_addr_in;
                        halted_q    <= halted_in;
                        state_q     <= ACCESS;
                    end else if (accept) begin
                        wb_valid_q        <= 1'b1;
                        wb_register_src_q <= register_src_in;
                        wb_rd_num_q       <= rd_num_in;
                        wb_is_word_q      <= is_word_in;
                        wb_byte_number_q  <= alu_result_in[1:0];
                        wb_alu_result_q   <= alu_result_in;
                        wb_inst_addr_q    <= inst_addr_in;
                        wb_halted_q       <= wb_halted_q || halted_in;
                    end
                end
                ACCESS: begin
                    if (cache_ready || timeout_hit) begin
                        wb_valid_q        <= 1'b1;
                        wb_register_src_q <= reg_src_q;
                        wb_rd_num_q       <= rd_num_q;
                        wb_is_word_q      <= is_word_q;
                        wb_byte_number_q  <= addr_q[1:0];
                        wb_alu_result_q   <= addr_q;
                        wb_inst_addr_q    <= inst_addr_q;
                        wb_halted_q       <= wb_halted_q || halted_q;
                        if (cache_ready) begin
                            if (load_q) begin
                                wb_cache_data_q <= cache_rdata;
                            end
                        end else begin
                            wb_cache_data_q <= '0;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of single transactions plus
// hand-written sequences for reset, halt and (optionally) timeout.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        in_valid, mem_read, mem_write, is_word_in, halted_in;
    logic [31:0] alu_result_in, store_data, inst_addr_in;
    logic [4:0]  rd_num_in;
    logic [1:0]  register_src_in;
    logic        stall, cache_req, cache_we, cache_ready;
    logic [31:0] cache_addr, cache_wdata, cache_rdata;
    logic [3:0]  cache_be;
    logic        wb_valid, wb_is_word, wb_halted, mem_error;
    logic [1:0]  wb_register_src, wb_byte_number;
    logic [4:0]  wb_rd_num;
    logic [31:0] wb_alu_result, wb_inst_addr, wb_cache_data;

    int tests = 0;
    int fails = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .is_word_in(is_word_in), .alu_result_in(alu_result_in),
        .store_data(store_data), .rd_num_in(rd_num_in), .register_src_in(register_src_in),
        .inst_addr_in(inst_addr_in), .halted_in(halted_in), .stall(stall),
        .cache_req(cache_req), .cache_we(cache_we), .cache_addr(cache_addr),
        .cache_be(cache_be), .cache_wdata(cache_wdata), .cache_ready(cache_ready),
        .cache_rdata(cache_rdata), .wb_valid(wb_valid), .wb_register_src(wb_register_src),
        .wb_rd_num(wb_rd_num), .wb_is_word(wb_is_word), .wb_byte_number(wb_byte_number),
        .wb_alu_result(wb_alu_result), .wb_inst_addr(wb_inst_addr),
        .wb_cache_data(wb_cache_data), .wb_halted(wb_halted), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        word;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rdn;
        logic [1:0]  rsrc;
        logic [31:0] inst;
        int          delay;
        logic [31:0] rdata;
        logic [31:0] exp_caddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_cdata;
        logic [1:0]  exp_bn;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; mem_read = 0; mem_write = 0; is_word_in = 0; halted_in = 0;
        alu_result_in = 0; store_data = 0; rd_num_in = 0; register_src_in = 0;
        inst_addr_in = 0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic word,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rdn, input logic [1:0] rsrc,
                         input logic [31:0] inst, input logic halt);
        in_valid = 1; mem_read = rd; mem_write = wr; is_word_in = word;
        alu_result_in = addr; store_data = sdata; rd_num_in = rdn;
        register_src_in = rsrc; inst_addr_in = inst; halted_in = halt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic mem;
        vec_t v;

        //            rd wr wd addr          sdata         rdn   rsrc  inst          dly rdata         caddr         be       wdata         cdata         bn
        vt[0] = '{1'b0, 1'b0, 1'b0, 32'h00001234, 32'h00000000, 5'd5,  2'b00, 32'h00400000, 0, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 2'd0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 32'h00000100, 32'h11112222, 5'd8,  2'b01, 32'h00400004, 3, 32'hDEADBEEF, 32'h00000100, 4'b1111, 32'h11112222, 32'hDEADBEEF, 2'd0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 32'h00000203, 32'h000000A5, 5'd0,  2'b00, 32'h00400008, 0, 32'h55555555, 32'h00000200, 4'b0001, 32'hA5A5A5A5, 32'hDEADBEEF, 2'd3};
        vt[3] = '{1'b1, 1'b0, 1'b0, 32'h00000401, 32'h12345678, 5'd9,  2'b01, 32'h0040000C, 1, 32'hCAFEF00D, 32'h00000400, 4'b0100, 32'h78787878, 32'hCAFEF00D, 2'd1};
        vt[4] = '{1'b1, 1'b1, 1'b1, 32'h00000302, 32'h89ABCDEF, 5'd3,  2'b10, 32'h00400010, 2, 32'h0BADF00D, 32'h00000300, 4'b1111, 32'h89ABCDEF, 32'hCAFEF00D, 2'd2};
        vt[5] = '{1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000000, 5'd31, 2'b10, 32'h00400014, 0, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000000, 32'hCAFEF00D, 2'd3};
        vt[6] = '{1'b1, 1'b0, 1'b0, 32'h00000500, 32'h00000000, 5'd4,  2'b01, 32'h00400018, 2, 32'h01020304, 32'h00000500, 4'b1000, 32'h00000000, 32'h01020304, 2'd0};

        rst_b = 0; cache_ready = 0; cache_rdata = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", 32'(stall), 0);
        chk("reset cache_req", 32'(cache_req), 0);
        chk("reset wb_valid", 32'(wb_valid), 0);
        chk("reset wb_cache_data", wb_cache_data, 0);
        chk("reset wb_halted", 32'(wb_halted), 0);
        chk("reset mem_error", 32'(mem_error), 0);
        rst_b = 1;
        step();

        for (int i = 0; i < 7; i++) begin
            v = vt[i];
            mem = v.rd | v.wr;
            drive(v.rd, v.wr, v.word, v.addr, v.sdata, v.rdn, v.rsrc, v.inst, 1'b0);
            #1;
            chk($sformatf("v%0d accept stall", i), 32'(stall), 32'(mem));
            chk($sformatf("v%0d accept cache_req", i), 32'(cache_req), 0);
            step();
            idle_inputs();
            if (mem) begin
                chk($sformatf("v%0d cache_req", i), 32'(cache_req), 1);
                chk($sformatf("v%0d cache_addr", i), cache_addr, v.exp_caddr);
                chk($sformatf("v%0d cache_be", i), 32'(cache_be), 32'(v.exp_be));
                chk($sformatf("v%0d cache_we", i), 32'(cache_we), 32'(v.wr));
                chk($sformatf("v%0d cache_wdata", i), cache_wdata, v.exp_wdata);
                for (int d = 0; d < v.delay; d++) begin
                    chk($sformatf("v%0d wait stall", i), 32'(stall), 1);
                    step();
                    chk($sformatf("v%0d held cache_addr", i), cache_addr, v.exp_caddr);
                end
                cache_ready = 1; cache_rdata = v.rdata;
                #1;
                chk($sformatf("v%0d ready stall", i), 32'(stall), 0);
                step();
                cache_ready = 0; cache_rdata = 0;
            end
            chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 1);
            chk($sformatf("v%0d wb_alu_result", i), wb_alu_result, v.addr);
            chk($sformatf("v%0d wb_rd_num", i), 32'(wb_rd_num), 32'(v.rdn));
            chk($sformatf("v%0d wb_register_src", i), 32'(wb_register_src), 32'(v.rsrc));
            chk($sformatf("v%0d wb_inst_addr", i), wb_inst_addr, v.inst);
            chk($sformatf("v%0d wb_is_word", i), 32'(wb_is_word), 32'(v.word));
            chk($sformatf("v%0d wb_byte_number", i), 32'(wb_byte_number), 32'(v.exp_bn));
            chk($sformatf("v%0d wb_cache_data", i), wb_cache_data, v.exp_cdata);
            chk($sformatf("v%0d post cache_req", i), 32'(cache_req), 0);
            step();
            chk($sformatf("v%0d wb_valid drop", i), 32'(wb_valid), 0);
        end

        // Stray ready pulse while idle
        cache_ready = 1; cache_rdata = 32'hFFFFFFFF;
        step();
        cache_ready = 0; cache_rdata = 0;
        chk("stray ready wb_valid", 32'(wb_valid), 0);
        chk("stray ready wb_cache_data", wb_cache_data, 32'h01020304);
        chk("stray ready cache_req", 32'(cache_req), 0);

        // Reset while a load is outstanding
        drive(1'b1, 1'b0, 1'b1, 32'h00000600, 32'h0, 5'd7, 2'b01, 32'h00400020, 1'b0);
        step();
        idle_inputs();
        step();
        chk("midreset pre cache_req", 32'(cache_req), 1);
        rst_b = 0;
        #1;
        chk("midreset cache_req", 32'(cache_req), 0);
        chk("midreset stall", 32'(stall), 0);
        chk("midreset wb_alu_result", wb_alu_result, 0);
        chk("midreset wb_cache_data", wb_cache_data, 0);
        chk("midreset wb_inst_addr", wb_inst_addr, 0);
        chk("midreset wb_rd_num", 32'(wb_rd_num), 0);
        step();
        rst_b = 1;
        step();
        chk("postreset cache_req", 32'(cache_req), 0);
        chk("postreset wb_valid", 32'(wb_valid), 0);
        drive(1'b0, 1'b0, 1'b0, 32'h00000077, 32'h0, 5'd2, 2'b00, 32'h00400024, 1'b0);
        step();
        idle_inputs();
        chk("postreset alu wb_valid", 32'(wb_valid), 1);
        chk("postreset alu wb_alu_result", wb_alu_result, 32'h00000077);
        step();

`ifdef MEM_TIMEOUT_EN
        // Cache never answers: abort after four ACCESS cycles
        drive(1'b1, 1'b0, 1'b1, 32'h00000700, 32'h0, 5'd6, 2'b01, 32'h00400028, 1'b0);
        step();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            chk("timeout wait cache_req", 32'(cache_req), 1);
            chk("timeout wait stall", 32'(stall), 1);
            chk("timeout wait mem_error", 32'(mem_error), 0);
            step();
        end
        chk("timeout last cache_req", 32'(cache_req), 1);
        chk("timeout last stall", 32'(stall), 0);
        step();
        chk("timeout wb_valid", 32'(wb_valid), 1);
        chk("timeout mem_error", 32'(mem_error), 1);
        chk("timeout wb_cache_data", wb_cache_data, 0);
        chk("timeout cache_req", 32'(cache_req), 0);
        chk("timeout stall", 32'(stall), 0);
        step();
        chk("timeout mem_error sticky", 32'(mem_error), 1);
`else
        chk("no-timeout mem_error", 32'(mem_error), 0);
`endif

        // Halt bundle retires, later bundles are ignored
        drive(1'b0, 1'b0, 1'b0, 32'h00000099, 32'h0, 5'd1, 2'b00, 32'h0040002C, 1'b1);
        step();
        idle_inputs();
        chk("halt wb_valid", 32'(wb_valid), 1);
        chk("halt wb_halted", 32'(wb_halted), 1);
        chk("halt wb_alu_result", wb_alu_result, 32'h00000099);
        drive(1'b1, 1'b0, 1'b1, 32'h00000800, 32'h0, 5'd10, 2'b01, 32'h00400030, 1'b0);
        #1;
        chk("halted load stall", 32'(stall), 0);
        step();
        chk("halted load cache_req", 32'(cache_req), 0);
        chk("halted load wb_valid", 32'(wb_valid), 0);
        chk("halted sticky", 32'(wb_halted), 1);
        step();
        chk("halted load cache_req 2", 32'(cache_req), 0);
        chk("halted wb_alu_result held", wb_alu_result, 32'h00000099);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
